fib_seq_gen: RTL and testbench

Parametrised Fibonacci-style sequence generator with registered state, a start/step handshake, a saturating step counter and combinational property flags. It is the generalised successor of the fixed 8-bit x/y accumulator used as a model-checking target. It sits in the formal/regression test set as a configurable design-under-proof: seeds, widths, stop limit and flag targets are all parameters, so one RTL block covers many property instances.

---
 rtl/fib_seq_gen.sv | 142 ++++++++++++++
 tb/tb_fib_seq_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_gen.sv
// fib_seq_gen -- parametrised Fibonacci-style sequence generator.
//
// Holds an x/y register pair that advances x <= x+y, y <= x on each accepted
// step while x is below LIMIT. Once a step finds x at or above LIMIT, y takes
// x and the block parks in DONE. A saturating counter tracks accepted steps
// since the last start. Four combinational flags decode the registered x/y
// against parameterised targets, which lets one block serve many property
// instances.
//
// Ports:
//   clk      in   rising-edge clock for all state
//   reset    in   synchronous, active-low; returns to IDLE with seeds loaded
//   start    in   load seeds, clear steps/ovf, enter RUN (any state; beats step_en)
//   step_en  in   advance one step while in RUN
//   x, y     out  WIDTH-bit sequence registers
//   steps    out  CNT_W-bit accepted-step count, saturates at all-ones
//   busy     out  state == RUN
//   done     out  state == DONE
//   ovf      out  sticky add carry-out flag (saturating build only, else 0)
//   z1..z4   out  property flags decoded from registered x/y
//
// Build option:
//   FIB_SEQ_GEN_SAT_EN  when defined, a carry out of x+y clamps x to all-ones
//                       and sets ovf. When undefined, the sum wraps and ovf is
//                       tied low.

module fib_seq_gen #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      CNT_W    = 8,
    parameter logic [WIDTH-1:0] X0       = WIDTH'(1),
    parameter logic [WIDTH-1:0] Y0       = WIDTH'(1),
    parameter logic [WIDTH-1:0] LIMIT    = WIDTH'(100),
    parameter logic [WIDTH-1:0] TARGET_A = WIDTH'(8),
    parameter logic [WIDTH-1:0] TARGET_B = WIDTH'(144),
    parameter logic [WIDTH-1:0] HI_MARK  = WIDTH'(200)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_en,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] steps,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             z1,
    output logic             z2,
    output logic             z3,
    output logic             z4
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] x_nx, y_nx;
    logic [CNT_W-1:0] steps_nx;
    logic [WIDTH-1:0] add_res;
    logic             do_step;
    logic             below_lim;

    // Only a RUN-state step_en without a competing start advances the sequence.
    assign do_step   = (state == RUN) && step_en && !start;
    assign below_lim = (x < LIMIT);

`ifdef FIB_SEQ_GEN_SAT_EN
    logic [WIDTH:0] sum_w;
    logic           ovf_q, ovf_nx;

    assign sum_w   = {1'b0, x} + {1'b0, y};
    assign add_res = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];

    // Sticky: only start or reset clear it. An add that is blocked by LIMIT
    // never sets it.
    always_comb begin
        ovf_nx = ovf_q;
        if (start)
            ovf_nx = 1'b0;
        else if (do_step && below_lim && sum_w[WIDTH])
            ovf_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_nx;
    end

    assign ovf = ovf_q;
`else
    assign add_res = x + y;
    assign ovf     = 1'b0;
`endif

    // Next-state and datapath. start is checked first so it wins over
    // step_en in every state.
    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        steps_nx = steps;
        if (start) begin
            state_nx = RUN;
            x_nx     = X0;
            y_nx     = Y0;
            steps_nx = '0;
        end else if (do_step) begin
            // The counter saturates, but the sequence keeps going.
            if (steps != {CNT_W{1'b1}})
                steps_nx = steps + CNT_W'(1);
            // y takes the pre-step x on every accepted step, whether or not
            // the add happens.
            y_nx = x;
            if (below_lim)
                x_nx = add_res;
            else
                state_nx = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            x     <= X0;
            y     <= Y0;
            steps <= '0;
        end else begin
            state <= state_nx;
            x     <= x_nx;
            y     <= y_nx;
            steps <= steps_nx;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign z1 = (x == TARGET_A);
    assign z2 = (x == TARGET_B);
    assign z3 = (x > HI_MARK);
    assign z4 = (x == HI_MARK) || (y == HI_MARK);

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen. It runs four instances side by side:
//   u0 uses the defaults,
//   u1 uses LIMIT=255 to reach the add carry-out,
//   u2 uses HI_MARK=13 for the z3/z4 flags,
//   u3 uses CNT_W=3 so the step counter saturates.
// A behavioural model follows each instance using integer arithmetic, and
// the directed tasks also check the known sequence values from constants.

module tb_fib_seq_gen;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0]      start = '0;
    logic [N-1:0]      step_en = '0;
    logic [N-1:0][7:0] x, y;
    logic [2:0][7:0]   steps;
    logic [2:0]        steps3;
    logic [N-1:0]      busy, done, ovf, z1, z2, z3, z4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_seq_gen u0 (.clk(clk), .reset(reset), .start(start[0]), .step_en(step_en[0]),
        .x(x[0]), .y(y[0]), .steps(steps[0]), .busy(busy[0]), .done(done[0]), .ovf(ovf[0]),
        .z1(z1[0]), .z2(z2[0]), .z3(z3[0]), .z4(z4[0]));
    fib_seq_gen #(.LIMIT(8'd255)) u1 (.clk(clk), .reset(reset), .start(start[1]), .step_en(step_en[1]),
        .x(x[1]), .y(y[1]), .steps(steps[1]), .busy(busy[1]), .done(done[1]), .ovf(ovf[1]),
        .z1(z1[1]), .z2(z2[1]), .z3(z3[1]), .z4(z4[1]));
    fib_seq_gen #(.HI_MARK(8'd13)) u2 (.clk(clk), .reset(reset), .start(start[2]), .step_en(step_en[2]),
        .x(x[2]), .y(y[2]), .steps(steps[2]), .busy(busy[2]), .done(done[2]), .ovf(ovf[2]),
        .z1(z1[2]), .z2(z2[2]), .z3(z3[2]), .z4(z4[2]));
    fib_seq_gen #(.CNT_W(3)) u3 (.clk(clk), .reset(reset), .start(start[3]), .step_en(step_en[3]),
        .x(x[3]), .y(y[3]), .steps(steps3), .busy(busy[3]), .done(done[3]), .ovf(ovf[3]),
        .z1(z1[3]), .z2(z2[3]), .z3(z3[3]), .z4(z4[3]));

    // Reference model. Each instance gets its own limit, high mark and
    // counter maximum. State encoding: 0 idle, 1 run, 2 done.
    int lim[N]  = '{100, 255, 100, 100};
    int hi[N]   = '{200, 200, 13, 200};
    int smax[N] = '{255, 255, 255, 7};
    int mx[N], my[N], ms[N], mst[N], movf[N];

    task automatic model_reset(input int i);
        mx[i] = 1; my[i] = 1; ms[i] = 0; mst[i] = 0; movf[i] = 0;
    endtask

    task automatic model_step(input int i, input bit st, input bit se);
        int s;
        if (st) begin
            mx[i] = 1; my[i] = 1; ms[i] = 0; movf[i] = 0; mst[i] = 1;
        end else if (mst[i] == 1 && se) begin
            if (ms[i] < smax[i]) ms[i]++;
            if (mx[i] < lim[i]) begin
                s = mx[i] + my[i];
                my[i] = mx[i];
`ifdef FIB_SEQ_GEN_SAT_EN
                if (s > 255) begin mx[i] = 255; movf[i] = 1; end
                else mx[i] = s;
`else
                mx[i] = s % 256;
`endif
            end else begin
                my[i] = mx[i];
                mst[i] = 2;
            end
        end
    endtask

    // Expected outputs packed as {x, y, steps, busy, done, ovf, z1, z2, z3, z4}.
    function automatic logic [30:0] exp_vec(input int i);
        return {mx[i][7:0], my[i][7:0], ms[i][7:0], mst[i] == 1, mst[i] == 2, movf[i] != 0,
                mx[i] == 8, mx[i] == 144, mx[i] > hi[i], (mx[i] == hi[i]) || (my[i] == hi[i])};
    endfunction

    function automatic logic [30:0] obs_vec(input int i);
        logic [7:0] s;
        if (i == 3) s = {5'b0, steps3};
        else        s = steps[i];
        return {x[i], y[i], s, busy[i], done[i], ovf[i], z1[i], z2[i], z3[i], z4[i]};
    endfunction

    // One clock edge: the model sees the same inputs as the DUT, and
    // sampling happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!reset) model_reset(i);
            else        model_step(i, start[i], step_en[i]);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = '1; step_en = '1;
        tick(); tick();
        start = '0; step_en = '0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL reset_state u%0d got %h exp %h", i, obs_vec(i), exp_vec(i));
            end
        end
        checks++;
        if ({x[0], y[0], steps[0], busy[0], done[0]} !== {8'd1, 8'd1, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_const got x=%0d y=%0d st=%0d b=%b d=%b exp 1 1 0 0 0",
                     x[0], y[0], steps[0], busy[0], done[0]);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fib_run();
        int seq[10] = '{2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
        start[0] = 1'b1; start[3] = 1'b1;
        tick();
        start = '0;
        for (int k = 0; k < 10; k++) begin
            step_en[0] = 1'b1; step_en[3] = 1'b1;
            tick();
            checks++;
            if (x[0] !== 8'(seq[k]) || z1[0] !== (seq[k] == 8) || z2[0] !== (seq[k] == 144)) begin
                errors++;
                $display("FAIL fib_seq k=%0d got x=%0d z1=%b z2=%b exp x=%0d", k, x[0], z1[0], z2[0], seq[k]);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL fib_model k=%0d u%0d got %h exp %h", k, i, obs_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (steps[0] !== 8'd10 || busy[0] !== 1'b1 || steps3 !== 3'd7) begin
            errors++;
            $display("FAIL fib_ten got steps=%0d busy=%b steps3=%0d exp 10 1 7", steps[0], busy[0], steps3);
        end
        tick();
        checks++;
        if ({x[0], y[0], steps[0], done[0], busy[0]} !== {8'd144, 8'd144, 8'd11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fib_done got x=%0d y=%0d st=%0d d=%b b=%b exp 144 144 11 1 0",
                     x[0], y[0], steps[0], done[0], busy[0]);
        end
        tick(); tick();
        checks++;
        if ({x[0], y[0], steps[0], done[0]} !== {8'd144, 8'd144, 8'd11, 1'b1}) begin
            errors++;
            $display("FAIL done_hold got x=%0d y=%0d st=%0d d=%b exp 144 144 11 1", x[0], y[0], steps[0], done[0]);
        end
        checks++;
        if (obs_vec(3) !== exp_vec(3) || steps3 !== 3'd7) begin
            errors++;
            $display("FAIL cnt_sat got %h exp %h", obs_vec(3), exp_vec(3));
        end
        step_en = '0;
    endtask

    task automatic test_sat();
        int n = 0;
        start[1] = 1'b1;
        tick();
        start = '0;
        step_en[1] = 1'b1;
        while (x[1] !== 8'd233 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (x[1] !== 8'd233 || y[1] !== 8'd144) begin
            errors++;
            $display("FAIL sat_reach got x=%0d y=%0d exp 233 144", x[1], y[1]);
        end
        tick();
        step_en = '0;
        checks++;
`ifdef FIB_SEQ_GEN_SAT_EN
        if (x[1] !== 8'd255 || ovf[1] !== 1'b1 || y[1] !== 8'd233) begin
            errors++;
            $display("FAIL sat_clamp got x=%0d ovf=%b y=%0d exp 255 1 233", x[1], ovf[1], y[1]);
        end
`else
        if (x[1] !== 8'd121 || ovf[1] !== 1'b0 || y[1] !== 8'd233) begin
            errors++;
            $display("FAIL sat_wrap got x=%0d ovf=%b y=%0d exp 121 0 233", x[1], ovf[1], y[1]);
        end
`endif
        checks++;
        if (obs_vec(1) !== exp_vec(1)) begin
            errors++;
            $display("FAIL sat_model got %h exp %h", obs_vec(1), exp_vec(1));
        end
    endtask

    task automatic test_back_to_back();
        start[0] = 1'b1;
        tick();
        start = '0;
        step_en[0] = 1'b1;
        tick(); tick(); tick();
        start[0] = 1'b1;
        tick();
        start = '0; step_en = '0;
        checks++;
        if ({x[0], y[0], steps[0], busy[0]} !== {8'd1, 8'd1, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL start_prio got x=%0d y=%0d st=%0d b=%b exp 1 1 0 1", x[0], y[0], steps[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        start[0] = 1'b1;
        tick();
        start = '0;
        step_en[0] = 1'b1;
        repeat (5) tick();
        checks++;
        if (steps[0] !== 8'd5 || x[0] !== 8'd13) begin
            errors++;
            $display("FAIL mid_pre got steps=%0d x=%0d exp 5 13", steps[0], x[0]);
        end
        reset = 1'b0; start[0] = 1'b1;
        tick();
        reset = 1'b1; start = '0;
        checks++;
        if ({x[0], y[0], steps[0], busy[0], done[0]} !== {8'd1, 8'd1, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got x=%0d y=%0d st=%0d b=%b d=%b exp 1 1 0 0 0",
                     x[0], y[0], steps[0], busy[0], done[0]);
        end
        repeat (3) tick();
        step_en = '0;
        checks++;
        if ({x[0], y[0], steps[0], busy[0]} !== {8'd1, 8'd1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL idle_ignore got x=%0d y=%0d st=%0d b=%b exp 1 1 0 0", x[0], y[0], steps[0], busy[0]);
        end
    endtask

    task automatic test_himark();
        bit z3e[7] = '{0, 0, 0, 0, 0, 1, 1};
        bit z4e[7] = '{0, 0, 0, 0, 1, 1, 0};
        start[2] = 1'b1;
        tick();
        start = '0;
        step_en[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (z3[2] !== z3e[k] || z4[2] !== z4e[k]) begin
                errors++;
                $display("FAIL himark k=%0d got z3=%b z4=%b exp z3=%b z4=%b x=%0d y=%0d",
                         k, z3[2], z4[2], z3e[k], z4e[k], x[2], y[2]);
            end
        end
        step_en = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < N; i++) begin
                start[i]   = ($urandom_range(0, 24) == 0);
                step_en[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random c=%0d u%0d got %h exp %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
        end
        reset = 1'b1; start = '0; step_en = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) model_reset(i);
        test_reset();
        test_fib_run();
        test_sat();
        test_back_to_back();
        test_reset_mid();
        test_himark();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
